hazard_scoreboard: RTL and testbench



---
 rtl/hazard_scoreboard.sv | 177 +++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   ID-stage hazard unit. It has two parts:
//     - the classic single-cycle load-use interlock against the EX slot;
//     - a register scoreboard for long-latency producers, which can write back
//       out of order. It also tracks how many long ops are in flight.
//   Both stall outputs are purely combinational. The pipeline control muxes
//   them into its ID hold / EX bubble logic.
//
// Parameters
//   REG_LOG   register index width (2**REG_LOG architectural registers)
//   NUM_SRC   source operands per ID instruction
//   MAX_OUT   maximum number of outstanding long-latency ops (>= 1)
//   WB_BYPASS 1: a write-back of a source register in the same cycle hides its
//             RAW stall
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   id_valid          valid instruction in ID
//   id_rs             packed ID sources; operand 0 occupies the MSBs
//   id_rs_used        per-source read enable; bit i belongs to operand i
//   id_rd             ID destination register
//   id_long           ID instruction is a long-latency producer
//   id_advance        ID instruction moves into EX this cycle
//   ex_mem_read       EX holds a single-cycle load
//   ex_rd             EX destination register
//   wb_valid, wb_rd   a long op writes back register wb_rd this cycle
//   stall_from_Load   load-use stall of ID
//   flush_from_Load   bubble request into EX (same as stall_from_Load)
//   stall_from_Score  RAW / WAW / capacity stall of ID
//   busy_cnt          registered count of outstanding long ops
//   err_underflow     sticky: a write-back arrived with nothing outstanding
//
// Optional feature
//   Define HAZARD_PERF_EN to add stall_cycles[31:0]. It is a saturating count
//   of the cycles in which either stall output was high.
module hazard_scoreboard #(
  parameter int REG_LOG   = 5,
  parameter int NUM_SRC   = 3,
  parameter int MAX_OUT   = 4,
  parameter int WB_BYPASS = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         id_valid,
  input  logic [REG_LOG*NUM_SRC-1:0]   id_rs,
  input  logic [NUM_SRC-1:0]           id_rs_used,
  input  logic [REG_LOG-1:0]           id_rd,
  input  logic                         id_long,
  input  logic                         id_advance,
  input  logic                         ex_mem_read,
  input  logic [REG_LOG-1:0]           ex_rd,
  input  logic                         wb_valid,
  input  logic [REG_LOG-1:0]           wb_rd,
  output logic                         stall_from_Load,
  output logic                         flush_from_Load,
  output logic                         stall_from_Score,
  output logic [$clog2(MAX_OUT+1)-1:0] busy_cnt,
  output logic                         err_underflow
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]                  stall_cycles
`endif
);

  localparam int NREG = 2 ** REG_LOG;
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);
  localparam logic BYPASS_EN = (WB_BYPASS != 0);

  logic [NREG-1:0]    pend_q, pend_d;
  logic [CNT_W-1:0]   busy_q, busy_d;
  logic               err_q, err_d;

  logic [NUM_SRC-1:0] load_hit;
  logic [NUM_SRC-1:0] raw_hit;
  logic               waw_hit;
  logic               cap_hit;
  logic               stall_load;
  logic               stall_score;
  logic               iss;

  // Per-source comparisons. Register 0 is excluded here, so it can never
  // match the EX destination. It also never pends, so it cannot cause a
  // RAW stall.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REG_LOG-1:0] src;
      logic               active;
      logic               wb_same;

      assign src     = id_rs[REG_LOG*(NUM_SRC-gi)-1 -: REG_LOG];
      assign active  = id_valid & id_rs_used[gi] & (src != '0);
      assign wb_same = BYPASS_EN & wb_valid & (wb_rd == src);

      assign load_hit[gi] = active & (src == ex_rd);
      assign raw_hit[gi]  = active & pend_q[src] & ~wb_same;
    end
  endgenerate

  // The same-cycle write-back bypass applies only to reads. A WAW hazard still
  // stalls because the new producer would otherwise be cleared by the older one.
  assign waw_hit = id_valid & (id_rd != '0) & pend_q[id_rd];
  assign cap_hit = id_valid & id_long & (busy_q == MAX_CNT);

  assign stall_load  = ex_mem_read & (|ex_rd) & (|load_hit);
  assign stall_score = (|raw_hit) | waw_hit | cap_hit;

  assign stall_from_Load  = stall_load;
  assign flush_from_Load  = stall_load;
  assign stall_from_Score = stall_score;

  // An advance request that arrives while stalled is ignored. This keeps the
  // state consistent even when the pipeline control misbehaves.
  assign iss = id_advance & id_valid & id_long & ~stall_load & ~stall_score;

  // Scoreboard next state. If the same register is set and cleared in one
  // cycle, the set wins, because the new producer is still outstanding.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
      if (gi == 0) begin : g_zero
        assign pend_d[gi] = 1'b0;
      end else begin : g_reg
        logic set_hit;
        logic clr_hit;
        assign set_hit    = iss & (id_rd == REG_LOG'(gi));
        assign clr_hit    = wb_valid & (wb_rd == REG_LOG'(gi));
        assign pend_d[gi] = set_hit | (pend_q[gi] & ~clr_hit);
      end
    end
  endgenerate

  // Outstanding count. A write-back to r0 still retires an op.
  // When an issue and a write-back coincide, the count is left unchanged.
  always_comb begin
    busy_d = busy_q;
    err_d  = err_q;
    if (iss && !wb_valid) begin
      busy_d = busy_q + CNT_W'(1);
    end else if (wb_valid && !iss) begin
      if (busy_q != '0) begin
        busy_d = busy_q - CNT_W'(1);
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign busy_cnt      = busy_q;
  assign err_underflow = err_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else if ((stall_load || stall_score) && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam int MAX_OUT   = 4;
  localparam int WB_BYPASS = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [14:0] id_rs;
  logic [2:0]  id_rs_used;
  logic [4:0]  id_rd;
  logic        id_long;
  logic        id_advance;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        stall_from_Load;
  logic        flush_from_Load;
  logic        stall_from_Score;
  logic [2:0]  busy_cnt;
  logic        err_underflow;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .REG_LOG  (5),
    .NUM_SRC  (3),
    .MAX_OUT  (MAX_OUT),
    .WB_BYPASS(WB_BYPASS)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rs_used      (id_rs_used),
    .id_rd           (id_rd),
    .id_long         (id_long),
    .id_advance      (id_advance),
    .ex_mem_read     (ex_mem_read),
    .ex_rd           (ex_rd),
    .wb_valid        (wb_valid),
    .wb_rd           (wb_rd),
    .stall_from_Load (stall_from_Load),
    .flush_from_Load (flush_from_Load),
    .stall_from_Score(stall_from_Score),
    .busy_cnt        (busy_cnt),
    .err_underflow   (err_underflow)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles    (stall_cycles)
`endif
  );

  typedef struct {
    bit       rst;
    bit       v;
    bit [14:0] rs;
    bit [2:0] used;
    bit [4:0] rd;
    bit       lng;
    bit       adv;
    bit       exmr;
    bit [4:0] exrd;
    bit       wbv;
    bit [4:0] wbrd;
    bit       e_ld;
    bit       e_sc;
    int       e_busy;
    bit       e_err;
  } vec_t;

  vec_t tbl[$];

  // Reference model for the random phase: the list of outstanding long ops,
  // one entry per op, holding its destination register.
  int  outq[$];
  bit  err_m;

  function automatic bit [14:0] rs3(input bit [4:0] a, input bit [4:0] b, input bit [4:0] c);
    return {a, b, c};
  endfunction

  function automatic vec_t mk(input bit r, input bit v, input bit [14:0] rs, input bit [2:0] used,
                              input bit [4:0] rd, input bit lng, input bit adv, input bit exmr,
                              input bit [4:0] exrd, input bit wbv, input bit [4:0] wbrd,
                              input bit e_ld, input bit e_sc, input int e_busy, input bit e_err);
    vec_t t;
    t.rst = r; t.v = v; t.rs = rs; t.used = used; t.rd = rd; t.lng = lng; t.adv = adv;
    t.exmr = exmr; t.exrd = exrd; t.wbv = wbv; t.wbrd = wbrd;
    t.e_ld = e_ld; t.e_sc = e_sc; t.e_busy = e_busy; t.e_err = e_err;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input vec_t t);
    rst         = t.rst;
    id_valid    = t.v;
    id_rs       = t.rs;
    id_rs_used  = t.used;
    id_rd       = t.rd;
    id_long     = t.lng;
    id_advance  = t.adv;
    ex_mem_read = t.exmr;
    ex_rd       = t.exrd;
    wb_valid    = t.wbv;
    wb_rd       = t.wbrd;
  endtask

  function automatic bit model_pending(input bit [4:0] r);
    if (r == 0) return 1'b0;
    foreach (outq[k]) if (outq[k] == int'(r)) return 1'b1;
    return 1'b0;
  endfunction

  // Stall expectations computed straight from the hazard rules.
  function automatic void model_stalls(input vec_t t, output bit ld, output bit sc);
    ld = 1'b0;
    sc = 1'b0;
    if (t.v) begin
      for (int i = 0; i < 3; i++) begin
        bit [4:0] s;
        s = t.rs[(2 - i) * 5 +: 5];
        if (t.used[i] && s != 0) begin
          if (t.exmr && t.exrd != 0 && s == t.exrd) ld = 1'b1;
          if (model_pending(s) && !(WB_BYPASS != 0 && t.wbv && t.wbrd == s)) sc = 1'b1;
        end
      end
      if (model_pending(t.rd)) sc = 1'b1;
      if (t.lng && outq.size() == MAX_OUT) sc = 1'b1;
    end
  endfunction

  task automatic model_step(input vec_t t, input bit ld, input bit sc);
    bit iss;
    if (t.rst) begin
      outq.delete();
      err_m = 1'b0;
    end else begin
      iss = t.adv && t.v && t.lng && !ld && !sc;
      if (t.wbv) begin
        if (outq.size() == 0) begin
          if (!iss) err_m = 1'b1;
        end else begin
          for (int k = 0; k < outq.size(); k++) begin
            if (outq[k] == int'(t.wbrd)) begin
              outq.delete(k);
              break;
            end
          end
        end
      end
      if (iss) outq.push_back(int'(t.rd));
    end
  endtask

  initial begin
    vec_t t;
    vec_t idle;
    bit   ld_m, sc_m;

    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    t = idle;
    t.rst = 1'b1;
    drive(t);
    repeat (2) @(posedge clk);
    #1;

    //         rst v  rs               used    rd lng adv mr exrd wbv wbrd ld sc busy err
    tbl.push_back(mk(1, 0, rs3(0,0,0),  3'b000, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0));
    // load-use on operand 0, then on operand 2, then with ex_rd = 0
    tbl.push_back(mk(0, 1, rs3(5,0,0),  3'b001, 0, 0, 0, 1, 5,  0, 0,  1, 0, 0, 0));
    tbl.push_back(mk(0, 1, rs3(5,0,0),  3'b001, 0, 0, 0, 1, 0,  0, 0,  0, 0, 0, 0));
    tbl.push_back(mk(0, 1, rs3(0,0,5),  3'b100, 0, 0, 0, 1, 5,  0, 0,  1, 0, 0, 0));
    tbl.push_back(mk(0, 1, rs3(5,0,9),  3'b100, 0, 0, 0, 1, 5,  0, 0,  0, 0, 0, 0));
    tbl.push_back(mk(0, 0, rs3(5,5,5),  3'b111, 0, 0, 0, 1, 5,  0, 0,  0, 0, 0, 0));
    // scoreboard RAW on r7, released by a same-cycle write-back
    tbl.push_back(mk(0, 1, rs3(0,0,0),  3'b000, 7, 1, 1, 0, 0,  0, 0,  0, 0, 1, 0));
    tbl.push_back(mk(0, 1, rs3(7,0,0),  3'b001, 0, 0, 1, 0, 0,  0, 0,  0, 1, 1, 0));
    tbl.push_back(mk(0, 1, rs3(7,0,0),  3'b001, 0, 0, 1, 0, 0,  0, 0,  0, 1, 1, 0));
    tbl.push_back(mk(0, 1, rs3(7,0,0),  3'b001, 0, 0, 1, 0, 0,  1, 7,  0, 0, 0, 0));
    tbl.push_back(mk(0, 1, rs3(7,0,0),  3'b001, 0, 0, 1, 0, 0,  0, 0,  0, 0, 0, 0));
    // capacity: fill r1..r4, a fifth long op stalls until one write-back
    tbl.push_back(mk(0, 1, rs3(0,0,0),  3'b000, 1, 1, 1, 0, 0,  0, 0,  0, 0, 1, 0));
    tbl.push_back(mk(0, 1, rs3(0,0,0),  3'b000, 2, 1, 1, 0, 0,  0, 0,  0, 0, 2, 0));
    tbl.push_back(mk(0, 1, rs3(0,0,0),  3'b000, 3, 1, 1, 0, 0,  0, 0,  0, 0, 3, 0));
    tbl.push_back(mk(0, 1, rs3(0,0,0),  3'b000, 4, 1, 1, 0, 0,  0, 0,  0, 0, 4, 0));
    tbl.push_back(mk(0, 1, rs3(0,0,0),  3'b000, 9, 1, 1, 0, 0,  0, 0,  0, 1, 4, 0));
    tbl.push_back(mk(0, 1, rs3(0,0,0),  3'b000, 9, 1, 0, 0, 0,  1, 1,  0, 1, 3, 0));
    tbl.push_back(mk(0, 1, rs3(0,0,0),  3'b000, 9, 1, 1, 0, 0,  0, 0,  0, 0, 4, 0));
    tbl.push_back(mk(0, 0, rs3(0,0,0),  3'b000, 0, 0, 0, 0, 0,  1, 2,  0, 0, 3, 0));
    tbl.push_back(mk(0, 0, rs3(0,0,0),  3'b000, 0, 0, 0, 0, 0,  1, 3,  0, 0, 2, 0));
    tbl.push_back(mk(0, 0, rs3(0,0,0),  3'b000, 0, 0, 0, 0, 0,  1, 4,  0, 0, 1, 0));
    tbl.push_back(mk(0, 0, rs3(0,0,0),  3'b000, 0, 0, 0, 0, 0,  1, 9,  0, 0, 0, 0));
    // set of r6 together with a write-back naming r6: set wins, count unchanged
    tbl.push_back(mk(0, 1, rs3(0,0,0),  3'b000, 5, 1, 1, 0, 0,  0, 0,  0, 0, 1, 0));
    tbl.push_back(mk(0, 1, rs3(0,0,0),  3'b000, 6, 1, 1, 0, 0,  1, 6,  0, 0, 1, 0));
    tbl.push_back(mk(0, 1, rs3(0,0,0),  3'b000, 6, 0, 0, 0, 0,  0, 0,  0, 1, 1, 0));
    tbl.push_back(mk(0, 1, rs3(0,6,0),  3'b010, 0, 0, 0, 0, 0,  1, 6,  0, 0, 0, 0));
    tbl.push_back(mk(0, 1, rs3(0,6,0),  3'b010, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0));
    tbl.push_back(mk(0, 1, rs3(0,0,0),  3'b000, 5, 0, 0, 0, 0,  0, 0,  0, 1, 0, 0));
    tbl.push_back(mk(0, 1, rs3(0,0,5),  3'b100, 0, 0, 0, 0, 0,  0, 0,  0, 1, 0, 0));
    tbl.push_back(mk(0, 1, rs3(5,5,5),  3'b000, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0));
    // register 0: a long op to r0 counts but never pends or matches
    tbl.push_back(mk(0, 1, rs3(0,0,0),  3'b000, 0, 1, 1, 0, 0,  0, 0,  0, 0, 1, 0));
    tbl.push_back(mk(0, 1, rs3(0,0,0),  3'b111, 0, 0, 0, 1, 0,  0, 0,  0, 0, 1, 0));
    tbl.push_back(mk(0, 0, rs3(0,0,0),  3'b000, 0, 0, 0, 0, 0,  1, 0,  0, 0, 0, 0));
    // underflow is sticky
    tbl.push_back(mk(0, 0, rs3(0,0,0),  3'b000, 0, 0, 0, 0, 0,  1, 3,  0, 0, 0, 1));
    tbl.push_back(mk(0, 0, rs3(0,0,0),  3'b000, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 1));
    // reset mid-operation with three outstanding ops
    tbl.push_back(mk(0, 1, rs3(0,0,0),  3'b000, 10, 1, 1, 0, 0, 0, 0,  0, 0, 1, 1));
    tbl.push_back(mk(0, 1, rs3(0,0,0),  3'b000, 11, 1, 1, 0, 0, 0, 0,  0, 0, 2, 1));
    tbl.push_back(mk(0, 1, rs3(0,0,0),  3'b000, 12, 1, 1, 0, 0, 0, 0,  0, 0, 3, 1));
    tbl.push_back(mk(1, 1, rs3(0,0,0),  3'b000, 13, 1, 1, 0, 0, 1, 10, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, rs3(10,11,12), 3'b111, 5, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    tbl.push_back(mk(0, 0, rs3(0,0,0),  3'b000, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i]);
      #3;
      chk($sformatf("row%0d_ld", i), stall_from_Load, tbl[i].e_ld);
      chk($sformatf("row%0d_flush", i), flush_from_Load, tbl[i].e_ld);
      chk($sformatf("row%0d_score", i), stall_from_Score, tbl[i].e_sc);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_busy", i), busy_cnt, tbl[i].e_busy);
      chk($sformatf("row%0d_err", i), err_underflow, tbl[i].e_err);
      $display("row %0d: ld=%0b score=%0b busy=%0d err=%0b", i, stall_from_Load,
               stall_from_Score, busy_cnt, err_underflow);
    end

    // Random phase against the outstanding-op list model.
    t = idle;
    t.rst = 1'b1;
    drive(t);
    model_step(t, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    for (int c = 0; c < 400; c++) begin
      t = idle;
      t.v    = 1'($urandom_range(0, 1));
      t.rs   = rs3(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      t.used = 3'($urandom_range(0, 7));
      t.rd   = 5'($urandom_range(0, 7));
      t.lng  = ($urandom_range(0, 2) != 0);
      t.adv  = ($urandom_range(0, 3) != 0);
      t.exmr = 1'($urandom_range(0, 1));
      t.exrd = 5'($urandom_range(0, 7));
      if (outq.size() != 0 && $urandom_range(0, 2) == 0) begin
        t.wbv  = 1'b1;
        t.wbrd = 5'(outq[$urandom_range(0, outq.size() - 1)]);
      end else if (outq.size() == 0 && $urandom_range(0, 49) == 0) begin
        t.wbv  = 1'b1;
        t.wbrd = 5'($urandom_range(0, 31));
        t.adv  = 1'b0;
      end
      drive(t);
      model_stalls(t, ld_m, sc_m);
      #3;
      chk($sformatf("rnd%0d_ld", c), stall_from_Load, ld_m);
      chk($sformatf("rnd%0d_flush", c), flush_from_Load, ld_m);
      chk($sformatf("rnd%0d_score", c), stall_from_Score, sc_m);
      model_step(t, ld_m, sc_m);
      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d_busy", c), busy_cnt, outq.size());
      chk($sformatf("rnd%0d_err", c), err_underflow, err_m);
      $display("rnd %0d: ld=%0b score=%0b busy=%0d err=%0b", c, stall_from_Load,
               stall_from_Score, busy_cnt, err_underflow);
    end

`ifdef HAZARD_PERF_EN
    t = idle;
    t.rst = 1'b1;
    drive(t);
    @(posedge clk);
    #1;
    chk("perf_reset", stall_cycles, 32'd0);
    t = mk(0, 1, rs3(5,0,0), 3'b001, 0, 0, 0, 1, 5, 0, 0, 1, 0, 0, 0);
    drive(t);
    repeat (10) @(posedge clk);
    #1;
    chk("perf_ten", stall_cycles, 32'd10);
    dut.stall_cycles_q = 32'hFFFF_FFFE;
    repeat (3) @(posedge clk);
    #1;
    chk("perf_saturate", stall_cycles, 32'hFFFF_FFFF);
    $display("perf: stall_cycles=%0h", stall_cycles);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
